// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared types and defaults for the two-client stack controller.
//   arb_state_t : arbitration FSM encoding (ARB, LOCK0, LOCK1)
//   CL0/CL1     : client id constants, also used as the value of 'last'
//   *_DEF       : default data width / depth / address width
package stack_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic CL0 = 1'b0;
    localparam logic CL1 = 1'b1;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;

endpackage

// File: rtl/stack_ram.sv
// stack_ram: DW x DEPTH storage, one write port, one synchronous read port.
//   clk, reset : clock, synchronous active-low reset (clears read register only)
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata updates on the edge where re=1
//   rdata          : registered read data, holds while re=0
module stack_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Array is deliberately never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one LIFO between two clients with round-robin
// arbitration and an optional ownership lock for multi-op bursts.
//   clk, reset           : clock, synchronous active-low reset
//   push/pop/lock/din 0,1: per-client request (level, held until grant)
//   gnt0, gnt1           : combinational; the granted op commits this edge
//   rd_valid/owner/data  : pop result, one cycle after the pop grant
//   count, empty, full   : registered occupancy
//   ovf_err, unf_err     : one-cycle pulses for push-on-full / pop-on-empty
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push0,
    input  logic          pop0,
    input  logic          lock0,
    input  logic [DW-1:0] din0,
    input  logic          push1,
    input  logic          pop1,
    input  logic          lock1,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rd_valid,
    output logic          rd_owner,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf_err,
    output logic          unf_err
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);

    arb_state_t state, state_nx;
    logic       last;
    logic       req0, req1;
    logic       gnt_any, sel, op_push;
    logic       do_push, do_pop, wr_en, rd_en;
    logic [DW-1:0] din_sel;
    logic [AW-1:0] waddr, raddr;

    assign req0 = push0 | pop0;
    assign req1 = push1 | pop1;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Grant and next-state. Grants are suppressed in reset so nothing
    // commits on the reset edge.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_nx = state;
        if (reset) begin
            case (state)
                ARB: begin
                    if (req0 && req1) begin
                        gnt0 = (last != CL0);
                        gnt1 = (last == CL0);
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                    if (gnt0 && lock0)      state_nx = LOCK0;
                    else if (gnt1 && lock1) state_nx = LOCK1;
                end
                LOCK0: begin
                    gnt0 = req0;
                    if (!lock0) state_nx = ARB;
                end
                LOCK1: begin
                    gnt1 = req1;
                    if (!lock1) state_nx = ARB;
                end
                default: state_nx = ARB;
            endcase
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign sel     = gnt1 ? CL1 : CL0;
    // Push has priority over pop when a client raises both.
    assign op_push = sel ? push1 : push0;
    assign din_sel = sel ? din1 : din0;

    assign do_push = gnt_any &  op_push;
    assign do_pop  = gnt_any & ~op_push;
    assign wr_en   = do_push & ~full;
    assign rd_en   = do_pop  & ~empty;

    assign waddr = count[AW-1:0];
    // When full, count[AW-1:0] is 0 and the subtraction wraps to DEPTH-1.
    assign raddr = count[AW-1:0] - ONE_A;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ARB;
            last     <= CL1;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_owner <= CL0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            if (gnt_any) last <= sel;
            if (wr_en)      count <= count + ONE_C;
            else if (rd_en) count <= count - ONE_C;
            rd_valid <= rd_en;
            if (rd_en) rd_owner <= sel;
            ovf_err  <= do_push & full;
            unf_err  <= do_pop & empty;
        end
    end

    stack_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (din_sel),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed stimulus with a pop-data scoreboard.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push0 = 0, pop0 = 0, lock0 = 0, push1 = 0, pop1 = 0, lock1 = 0;
    logic [7:0] din0 = 0, din1 = 0;
    logic       gnt0, gnt1, rd_valid, rd_owner, empty, full, ovf_err, unf_err;
    logic [7:0] rd_data;
    logic [3:0] count;

    stack_arbiter #(.DW(8), .DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset),
        .push0(push0), .pop0(pop0), .lock0(lock0), .din0(din0),
        .push1(push1), .pop1(pop1), .lock1(lock1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_valid(rd_valid), .rd_owner(rd_owner), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycnt = 0;

    always @(posedge clk) cycnt <= cycnt + 1;

    typedef struct {
        int         due;
        logic       own;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every rd_valid must match the oldest expected pop result,
    // arriving exactly one cycle after its grant.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got data %0h owner %0d, none pending", rd_data, rd_owner);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.dat || rd_owner !== e.own || cycnt != e.due) begin
                    bad++;
                    $display("FAIL rd_check: got data %0h owner %0d cyc %0d expected %0h %0d %0d",
                             rd_data, rd_owner, cycnt, e.dat, e.own, e.due);
                end
            end
        end
    end

    // One clock of stimulus; called and returns at posedge+1.
    task automatic cyc(input logic p0, o0, l0, input logic [7:0] d0,
                       input logic p1, o1, l1, input logic [7:0] d1,
                       input logic eg0, eg1, input logic er, input logic [7:0] ed,
                       input string nm);
        exp_t e;
        push0 = p0; pop0 = o0; lock0 = l0; din0 = d0;
        push1 = p1; pop1 = o1; lock1 = l1; din1 = d1;
        if (er) begin
            e.due = cycnt + 1; e.own = eg1; e.dat = ed;
            sb.push_back(e);
        end
        #3;
        chk({nm, "_gnt0"}, 32'(gnt0), 32'(eg0));
        chk({nm, "_gnt1"}, 32'(gnt1), 32'(eg1));
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, nm);
    endtask

    task automatic rst_cyc(input logic p0, input logic o0, input string nm);
        reset = 1'b0;
        push0 = p0; pop0 = o0; lock0 = 0; push1 = p0; pop1 = 0; lock1 = 0;
        #3;
        chk({nm, "_gnt0_forced"}, 32'(gnt0), 0);
        chk({nm, "_gnt1_forced"}, 32'(gnt1), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        push0 = 0; pop0 = 0; push1 = 0; pop1 = 0;
    endtask

    task automatic regs(input string nm, input int c, input int em, input int fu,
                        input int ov, input int un);
        chk({nm, "_count"}, 32'(count), c);
        chk({nm, "_empty"}, 32'(empty), em);
        chk({nm, "_full"},  32'(full),  fu);
        chk({nm, "_ovf"},   32'(ovf_err), ov);
        chk({nm, "_unf"},   32'(unf_err), un);
    endtask

    logic [7:0] alt_exp [8] = '{8'hB3, 8'hA3, 8'hB2, 8'hA2, 8'hB1, 8'hA1, 8'hB0, 8'hA0};
    logic [7:0] t1_dat  [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        rst_cyc(1'b1, 1'b0, "rst");
        regs("rst", 0, 1, 0, 0, 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  32'(rd_data), 0);
        chk("rst_rd_owner", 32'(rd_owner), 0);

        // Both clients push continuously: grants alternate starting at client 0.
        for (int k = 0; k < 8; k++)
            cyc(1, 0, 0, 8'(8'hA0 + (k + 1) / 2), 1, 0, 0, 8'(8'hB0 + k / 2),
                (k % 2) == 0, (k % 2) == 1, 0, 8'h00, "alt");
        regs("alt_full", 8, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++)
            cyc(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, alt_exp[k], "altpop");
        regs("alt_empty", 0, 1, 0, 0, 0);

        // Client 0 pushes three, pops three: LIFO order.
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 0, t1_dat[k], 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, "t1push");
        regs("t1_mid", 3, 0, 0, 0, 0);
        for (int k = 2; k >= 0; k--)
            cyc(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, t1_dat[k], "t1pop");
        regs("t1_end", 0, 1, 0, 0, 0);
        idle("t1_idle");

        // Pop on empty: granted, unf pulse, no data, rd_data holds.
        cyc(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, "unf");
        regs("unf", 0, 1, 0, 0, 1);
        chk("unf_rd_valid", 32'(rd_valid), 0);
        chk("unf_rd_data",  32'(rd_data), 32'h11);
        idle("unf_idle");
        chk("unf_pulse_end", 32'(unf_err), 0);

        // Client 1 pushes 9 times; the 9th overflows.
        for (int k = 1; k <= 8; k++)
            cyc(0, 0, 0, 8'h00, 1, 0, 0, 8'(k), 0, 1, 0, 8'h00, "ovfpush");
        cyc(0, 0, 0, 8'h00, 1, 0, 0, 8'h09, 0, 1, 0, 8'h00, "ovf9");
        regs("ovf", 8, 0, 1, 1, 0);
        idle("ovf_idle");
        chk("ovf_pulse_end", 32'(ovf_err), 0);
        cyc(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 1, 8'h08, "ovfpop");
        idle("ovfpop_idle");
        regs("ovfpop", 7, 0, 0, 0, 0);

        rst_cyc(1'b0, 1'b0, "rst2");
        regs("rst2", 0, 1, 0, 0, 0);

        // Lock: client 0 owns the stack while lock0=1, client 1 waits.
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 1, 8'(8'h41 + k), 1, 0, 0, 8'h51, 1, 0, 0, 8'h00, "lock");
        cyc(1, 0, 0, 8'h44, 1, 0, 0, 8'h51, 1, 0, 0, 8'h00, "unlock");
        cyc(0, 0, 0, 8'h00, 1, 0, 1, 8'h51, 0, 1, 0, 8'h00, "cl1_after");
        regs("lock", 5, 0, 0, 0, 0);

        // Reset during a pop request, with client 1 holding a lock.
        rst_cyc(1'b0, 1'b1, "rst3");
        regs("rst3", 0, 1, 0, 0, 0);
        chk("rst3_rd_valid", 32'(rd_valid), 0);
        cyc(1, 0, 0, 8'hC1, 1, 0, 0, 8'hD1, 1, 0, 0, 8'h00, "post_rst");
        regs("post_rst", 1, 0, 0, 0, 0);
        idle("end_idle0");
        idle("end_idle1");
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
